// File: rtl/face_detect_pkg.sv
// Shared cascade constants, FSM state encodings and the saturating adder.
// sat_add is combinational and is reused by the window-scanner accumulator.
package face_detect_pkg;

  localparam int DATA_WIDTH_16   = 16;
  localparam int ACC_WIDTH       = 20;
  localparam int NUM_STAGES      = 25;
  localparam int STAGE_IDX_WIDTH = 5;

  // Working width of sat_add; callers sign-extend into it and truncate the result.
  localparam int SAT_W = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_COMPARE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      w
  );
    logic signed [SAT_W:0] one;
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    one = {{SAT_W{1'b0}}, 1'b1};
    sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (sum > hi)
      return hi[SAT_W-1:0];
    else if (sum < lo)
      return lo[SAT_W-1:0];
    else
      return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/stage_threshold_evaluator_if.sv
// Upstream classifier link plus window control/verdict signals of the evaluator.
// master = environment side, slave = evaluator side.
interface stage_threshold_evaluator_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int STAGE_IDX_WIDTH = 5
);
  logic                          i_start;
  logic                          i_vote_valid;
  logic signed [DATA_WIDTH-1:0]  i_vote;
  logic                          i_is_end_of_stage;
  logic signed [DATA_WIDTH-1:0]  i_stage_threshold;
  logic                          o_trigger_compare_stage;
  logic [STAGE_IDX_WIDTH-1:0]    o_stage_index;
  logic                          o_busy;
  logic                          o_done;
  logic                          o_is_candidate;

  modport master (
    output i_start, i_vote_valid, i_vote, i_is_end_of_stage, i_stage_threshold,
    input  o_trigger_compare_stage, o_stage_index, o_busy, o_done, o_is_candidate
  );

  modport slave (
    input  i_start, i_vote_valid, i_vote, i_is_end_of_stage, i_stage_threshold,
    output o_trigger_compare_stage, o_stage_index, o_busy, o_done, o_is_candidate
  );
endinterface

// File: rtl/stage_threshold_evaluator_accumulator.sv
// Signed clamping accumulator: one-cycle update, clear has priority over add.
// No backpressure; an add is taken on every cycle add_i is high.
module saturating_accumulator
  import face_detect_pkg::SAT_W, face_detect_pkg::sat_add;
#(
  parameter int ACC_WIDTH = 20,
  parameter int IN_WIDTH  = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        clr_i,
  input  logic                        add_i,
  input  logic signed [IN_WIDTH-1:0]  din_i,
  output logic signed [ACC_WIDTH-1:0] acc_o
);

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (add_i)
      acc_d = ACC_WIDTH'(sat_add(SAT_W'(acc_q), SAT_W'(din_i), ACC_WIDTH));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/stage_threshold_evaluator.sv
// Cascade stage evaluator: sums votes per stage, compares to threshold, advances or rejects.
// Verdict/next-stage trigger two cycles after the end-of-stage vote edge; inputs outside RUN are dropped.
module stage_threshold_evaluator
  import face_detect_pkg::ST_IDLE, face_detect_pkg::ST_RUN,
         face_detect_pkg::ST_COMPARE, face_detect_pkg::ST_DONE;
#(
  parameter int DATA_WIDTH_16   = face_detect_pkg::DATA_WIDTH_16,
  parameter int ACC_WIDTH       = face_detect_pkg::ACC_WIDTH,
  parameter int NUM_STAGES      = face_detect_pkg::NUM_STAGES,
  parameter int STAGE_IDX_WIDTH = face_detect_pkg::STAGE_IDX_WIDTH
) (
  input  logic                  clk_fpga,
  input  logic                  reset_fpga,
  stage_threshold_evaluator_if.slave bus
);

  logic [1:0]                     state_q, state_d;
  logic [STAGE_IDX_WIDTH-1:0]     stage_q, stage_d;
  logic                           trig_q, trig_d;
  logic                           cand_q, cand_d;
  logic                           acc_clr, acc_add;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    thr_ext;
  logic signed [DATA_WIDTH_16-1:0] vote;
  logic                           pass;
  logic                           last_stage;

  assign vote       = bus.i_vote;
  assign thr_ext    = ACC_WIDTH'(bus.i_stage_threshold);
  assign pass       = (acc >= thr_ext);
  assign last_stage = (stage_q == STAGE_IDX_WIDTH'(NUM_STAGES - 1));

  saturating_accumulator #(
    .ACC_WIDTH (ACC_WIDTH),
    .IN_WIDTH  (DATA_WIDTH_16)
  ) u_acc (
    .clk_i   (clk_fpga),
    .rst_n_i (reset_fpga),
    .clr_i   (acc_clr),
    .add_i   (acc_add),
    .din_i   (vote),
    .acc_o   (acc)
  );

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    trig_d  = 1'b0;
    cand_d  = cand_q;
    acc_clr = 1'b0;
    acc_add = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          acc_clr = 1'b1;
          stage_d = '0;
          cand_d  = 1'b0;
          trig_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.i_vote_valid) begin
          acc_add = 1'b1;
          if (bus.i_is_end_of_stage)
            state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        // A failing stage ends the window early; the remaining stages never run.
        if (pass && !last_stage) begin
          stage_d = stage_q + STAGE_IDX_WIDTH'(1);
          acc_clr = 1'b1;
          trig_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          cand_d  = pass;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      trig_q  <= 1'b0;
      cand_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      trig_q  <= trig_d;
      cand_q  <= cand_d;
    end
  end

  assign bus.o_trigger_compare_stage = trig_q;
  assign bus.o_stage_index           = stage_q;
  assign bus.o_busy                  = (state_q != ST_IDLE);
  assign bus.o_done                  = (state_q == ST_DONE);
  assign bus.o_is_candidate          = cand_q;

endmodule

// File: tb/tb_stage_threshold_evaluator.sv
// Directed and random cascade windows on a 2-stage/16-bit and a 25-stage/20-bit evaluator.
module tb_stage_threshold_evaluator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a_n, rst_b_n;
  bit                sel;
  logic              start, vv, eos;
  logic signed [15:0] vote, thr;

  stage_threshold_evaluator_if #(.DATA_WIDTH(16), .STAGE_IDX_WIDTH(5)) ifa ();
  stage_threshold_evaluator_if #(.DATA_WIDTH(16), .STAGE_IDX_WIDTH(5)) ifb ();

  assign ifa.i_start           = start & ~sel;
  assign ifa.i_vote_valid      = vv & ~sel;
  assign ifa.i_is_end_of_stage = eos & ~sel;
  assign ifa.i_vote            = vote;
  assign ifa.i_stage_threshold = thr;
  assign ifb.i_start           = start & sel;
  assign ifb.i_vote_valid      = vv & sel;
  assign ifb.i_is_end_of_stage = eos & sel;
  assign ifb.i_vote            = vote;
  assign ifb.i_stage_threshold = thr;

  stage_threshold_evaluator #(
    .DATA_WIDTH_16(16), .ACC_WIDTH(16), .NUM_STAGES(2), .STAGE_IDX_WIDTH(5)
  ) dut_a (
    .clk_fpga   (clk),
    .reset_fpga (rst_a_n),
    .bus        (ifa)
  );

  stage_threshold_evaluator #(
    .DATA_WIDTH_16(16), .ACC_WIDTH(20), .NUM_STAGES(25), .STAGE_IDX_WIDTH(5)
  ) dut_b (
    .clk_fpga   (clk),
    .reset_fpga (rst_b_n),
    .bus        (ifb)
  );

  logic       o_trig, o_busy, o_done, o_cand;
  logic [4:0] o_idx;
  assign o_trig = sel ? ifb.o_trigger_compare_stage : ifa.o_trigger_compare_stage;
  assign o_busy = sel ? ifb.o_busy : ifa.o_busy;
  assign o_done = sel ? ifb.o_done : ifa.o_done;
  assign o_cand = sel ? ifb.o_is_candidate : ifa.o_is_candidate;
  assign o_idx  = sel ? ifb.o_stage_index : ifa.o_stage_index;

  int n_assert = 0;
  int n_fail   = 0;

  // Stimulus tables: votes in order, per-stage vote counts and thresholds.
  int vq[$];
  int slen[$];
  int tq[$];
  int pend = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic stim_clear;
    vq.delete(); slen.delete(); tq.delete(); pend = 0;
  endtask

  task automatic av(input int v);
    vq.push_back(v); pend++;
  endtask

  task automatic es(input int t);
    slen.push_back(pend); tq.push_back(t); pend = 0;
  endtask

  function automatic longint clampw(input longint x, input int w);
    longint mx, mn;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    return (x > mx) ? mx : ((x < mn) ? mn : x);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_trig"}, o_trig, 0);
    chk({tag, "_idx"},  o_idx,  0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_cand"}, o_cand, 0);
  endtask

  // Drives one window from the tables and checks every stage boundary against the model.
  task automatic run_window(input bit which, input int nst, input int accw, input bit noise);
    int     vi, s;
    longint acc;
    bit     pass, exp_cand;
    sel = which; vi = 0; exp_cand = 0; pass = 0;
    if (noise) begin
      repeat (2) begin vv = 1; vote = 16'($urandom); eos = 1'($urandom); step; end
      vv = 0; eos = 0;
    end
    start = 1; step; start = 0;
    for (s = 0; s < nst; s++) begin
      chk("trig", o_trig, 1);
      chk("idx", o_idx, s);
      chk("busy", o_busy, 1);
      if (s == 0) chk("cand_clr", o_cand, 0);
      thr = 16'(tq[s]);
      acc = 0;
      for (int k = 0; k < slen[s]; k++) begin
        if (noise) begin
          repeat ($urandom_range(0, 2)) begin
            vv = 0; eos = 1'($urandom); start = 1'($urandom); step;
            chk("trig_gap", o_trig, 0);
          end
        end
        vv = 1; vote = 16'(vq[vi]); eos = (k == slen[s] - 1);
        start = noise ? 1'($urandom) : 1'b0;
        step;
        chk("trig_run", o_trig, 0);
        acc = clampw(acc + vq[vi], accw);
        vi++;
      end
      vv = 0; eos = 0; start = 0;
      chk("cmp_done", o_done, 0);
      pass = (acc >= tq[s]);
      step;
      if (!pass || s == nst - 1) begin
        exp_cand = pass;
        break;
      end
    end
    chk("done", o_done, 1);
    chk("cand", o_cand, exp_cand);
    chk("done_idx", o_idx, s);
    chk("done_trig", o_trig, 0);
    start = 1; step; start = 0;
    chk("idle_busy", o_busy, 0);
    chk("idle_done", o_done, 0);
    chk("held_cand", o_cand, exp_cand);
  endtask

  task automatic gen_random(input int nst, input int accw);
    longint sum, t;
    int     n, v;
    stim_clear;
    for (int s = 0; s < nst; s++) begin
      n = $urandom_range(1, 4);
      sum = 0;
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 2) == 0) v = int'(shortint'($urandom));
        else v = int'($urandom_range(0, 400)) - 200;
        av(v);
        sum = clampw(sum + v, accw);
      end
      if ($urandom_range(0, 15) == 0) t = sum + 1;
      else t = sum - $urandom_range(0, 3);
      es(int'(clampw(t, 16)));
    end
  endtask

  initial begin
    start = 0; vv = 0; eos = 0; vote = 0; thr = 0; sel = 0;
    rst_a_n = 0; rst_b_n = 0;
    repeat (2) step;
    sel = 0; #1 check_all_zero("rst_a");
    sel = 1; #1 check_all_zero("rst_b");
    rst_a_n = 1; rst_b_n = 1;
    step;

    // Two-stage pass: 25 >= 20, then 7 >= 7.
    stim_clear; av(10); av(20); av(-5); es(20); av(7); es(7);
    run_window(0, 2, 16, 0);
    run_window(0, 2, 16, 1);
    // Early reject: -2 < 0.
    stim_clear; av(-3); av(1); es(0);
    run_window(0, 2, 16, 0);
    // Zero sum against zero threshold passes.
    stim_clear; av(5); av(-5); es(0); av(0); es(0);
    run_window(0, 2, 16, 0);
    // Clamp at +32767, then -1 gives 32766 < 32767.
    stim_clear; repeat (20) av(32767); av(-1); es(32767);
    run_window(0, 2, 16, 0);
    stim_clear; repeat (20) av(32767); av(0); es(32767); av(0); es(0);
    run_window(0, 2, 16, 0);
    stim_clear; repeat (20) av(-32768); av(1); es(-32767); av(0); es(0);
    run_window(0, 2, 16, 0);

    // Asynchronous reset while stage 3 is running.
    sel = 1; start = 1; step; start = 0;
    for (int s = 0; s < 3; s++) begin
      vv = 1; vote = 5; eos = 1; thr = 0; step;
      vv = 0; eos = 0; step;
    end
    chk("pre_rst_idx", o_idx, 3);
    chk("pre_rst_trig", o_trig, 1);
    vv = 1; vote = 5; eos = 0; step; vv = 0;
    chk("pre_rst_busy", o_busy, 1);
    #2 rst_b_n = 0;
    #1 check_all_zero("mid_rst");
    repeat (3) begin step; chk("rst_no_done", o_done, 0); end
    rst_b_n = 1; step;
    stim_clear; av(3); es(3); av(-1); es(-1); av(2); es(5);
    run_window(1, 25, 20, 0);

    for (int w = 0; w < 30; w++) begin
      gen_random(25, 20);
      run_window(1, 25, 20, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
